// File: rtl/huffman_pkg.sv
// huffman_pkg
// Shared definitions for the Huffman stream coder. It holds the default
// parameter values, the Avalon-MM register map, the control and status bit
// positions, and the packer FSM state encoding.
package huffman_pkg;

  // Default parameter values
  localparam int DEF_SYM_WIDTH  = 6;
  localparam int DEF_MAX_LEN    = 12;
  localparam int DEF_OUT_WIDTH  = 32;
  localparam int DEF_FIFO_DEPTH = 8;

  // Register word addresses
  localparam logic [1:0] ADDR_LUT    = 2'd0;
  localparam logic [1:0] ADDR_PUSH   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // Control register bits (address 2, write only)
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  // Status register layout (address 3, read only)
  localparam int ST_OVERFLOW_BIT = 0;
  localparam int ST_BUSY_BIT     = 1;
  localparam int ST_FLUSH_BIT    = 2;
  localparam int ST_FIFO_CNT_LSB = 4;
  localparam int ST_FIFO_CNT_W   = 8;
  localparam int ST_FILL_LSB     = 16;
  localparam int ST_FILL_W       = 7;

  // Packer FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_EMIT   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

endpackage

// File: rtl/huffman_stream_coder_if.sv
// huffman_stream_coder_if
// Avalon-MM slave bus of the Huffman stream coder. It has no waitrequest, and
// readdata is valid one cycle after a read is sampled.
//   address    : word address (0 LUT, 1 push, 2 control, 3 status)
//   chipselect : qualifies read/write
//   read/write : access strobes
//   writedata  : write data
//   readdata   : registered read data
interface huffman_stream_coder_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/huff_sym_fifo.sv
// huff_sym_fifo
// This is a synchronous symbol FIFO with an occupancy count. A push that
// arrives while the FIFO is full is still accepted when a pop happens in the
// same cycle. The pointers wrap modulo DEPTH.
//   clock, resetn : clock and synchronous active-low reset
//   push, wr_data : write request and data
//   pop           : read request (ignored when empty)
//   rd_data       : head of the FIFO (combinational)
//   count         : number of stored entries
//   empty, full   : occupancy flags
module huff_sym_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok, rd_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign rd_ok = pop && !empty;
  assign wr_ok = push && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset. Only the pointers define which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/huffman_stream_coder.sv
// huffman_stream_coder
// This block encodes a stream of symbols with a programmable Huffman code
// table. Each symbol is looked up in a code LUT, and its codeword bits are
// packed MSB-first into OUT_WIDTH-bit words.
//   clock, resetn : clock and synchronous active-low reset
//   bus           : Avalon-MM slave (LUT write, symbol push, control, status)
//   encoded_out   : packed word. Its MSB holds the first-emitted bit, and it
//                   holds its value between strobes.
//   enable_out    : one-cycle strobe that qualifies encoded_out
module huffman_stream_coder
  import huffman_pkg::*;
#(
  parameter int SYM_WIDTH  = DEF_SYM_WIDTH,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clock,
  input  logic                   resetn,
  huffman_stream_coder_if.slave  bus,
  output logic [OUT_WIDTH-1:0]   encoded_out,
  output logic                   enable_out
);

  localparam int LEN_W     = $clog2(MAX_LEN+1);
  localparam int ENTRY_W   = LEN_W + MAX_LEN;
  localparam int LUT_DEPTH = 1 << SYM_WIDTH;
  // The accumulator only needs to hold less than one word plus one codeword.
  localparam int ACC_W     = OUT_WIDTH + MAX_LEN;
  localparam int FILL_W    = $clog2(ACC_W+1);
  localparam int CNT_W     = $clog2(FIFO_DEPTH+1);

  // Bus decode
  logic wr_lut, wr_push, wr_ctrl, rd_status;
  assign wr_lut    = bus.chipselect && bus.write && (bus.address == ADDR_LUT);
  assign wr_push   = bus.chipselect && bus.write && (bus.address == ADDR_PUSH);
  assign wr_ctrl   = bus.chipselect && bus.write && (bus.address == ADDR_CTRL);
  assign rd_status = bus.chipselect && bus.read  && (bus.address == ADDR_STATUS);

  // Only a slice of writedata is meaningful for each register.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  // Symbol FIFO
  logic                 fifo_pop;
  logic [SYM_WIDTH-1:0] fifo_rd_data;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty, fifo_full;

  huff_sym_fifo #(
    .WIDTH (SYM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push    (wr_push),
    .wr_data (bus.writedata[SYM_WIDTH-1:0]),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Code LUT: entry = {code, length}, taken from the writedata bits just above
  // the symbol. Both the write and the registered read sit in one process, so
  // a same-address write and read in one cycle returns the old entry.
  logic [ENTRY_W-1:0] lut_mem [LUT_DEPTH];
  logic [ENTRY_W-1:0] lut_rd_data;

  always_ff @(posedge clock) begin
    if (wr_lut) lut_mem[bus.writedata[SYM_WIDTH-1:0]] <= bus.writedata[SYM_WIDTH +: ENTRY_W];
    if (fifo_pop) lut_rd_data <= lut_mem[fifo_rd_data];
  end

  // Codeword decode and placement
  logic [LEN_W-1:0]   len_raw, len_eff;
  logic [MAX_LEN-1:0] code_masked;
  logic [FILL_W-1:0]  add_shift, new_fill;
  logic [ACC_W-1:0]   acc_add;

  state_e                 state_q, state_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [OUT_WIDTH-1:0]   enc_q, enc_d;
  logic                   en_q, en_d;
  logic                   flush_q, flush_d;
  logic                   ovf_q, ovf_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   flush_clr;
  logic [31:0]            status;

  always_comb begin
    len_raw     = lut_rd_data[LEN_W-1:0];
    len_eff     = (len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_raw;
    // Keep only the low len_eff bits of the right-justified code.
    code_masked = lut_rd_data[ENTRY_W-1:LEN_W] & ~({MAX_LEN{1'b1}} << len_eff);
    new_fill    = fill_q + FILL_W'(len_eff);
    // The accumulator is left-justified. New bits go directly below the current fill.
    add_shift   = FILL_W'(ACC_W) - new_fill;
    acc_add     = ACC_W'(code_masked) << add_shift;
  end

  // Packer FSM: next state and datapath
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    acc_d     = acc_q;
    enc_d     = enc_q;
    en_d      = 1'b0;
    fifo_pop  = 1'b0;
    flush_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Queued symbols always come before a pending flush.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_LOOKUP;
        end else if (flush_q) begin
          state_d = ST_FLUSH;
        end
      end
      ST_LOOKUP: begin
        acc_d   = acc_q | acc_add;
        fill_d  = new_fill;
        state_d = (new_fill >= FILL_W'(OUT_WIDTH)) ? ST_EMIT : ST_IDLE;
      end
      ST_EMIT: begin
        enc_d   = acc_q[ACC_W-1 -: OUT_WIDTH];
        en_d    = 1'b1;
        acc_d   = acc_q << OUT_WIDTH;
        fill_d  = fill_q - FILL_W'(OUT_WIDTH);
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        // Bits below the fill are always zero, so the top slice is already padded.
        if (fill_q != '0) begin
          enc_d = acc_q[ACC_W-1 -: OUT_WIDTH];
          en_d  = 1'b1;
        end
        fill_d    = '0;
        acc_d     = '0;
        flush_clr = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers
  always_comb begin
    flush_d = flush_q;
    if (flush_clr) flush_d = 1'b0;
    if (wr_ctrl && bus.writedata[CTRL_FLUSH_BIT]) flush_d = 1'b1;

    ovf_d = ovf_q;
    if (wr_ctrl && bus.writedata[CTRL_CLR_OVF_BIT]) ovf_d = 1'b0;
    if (wr_push && fifo_full && !fifo_pop) ovf_d = 1'b1;

    status = '0;
    status[ST_FILL_LSB +: ST_FILL_W]         = ST_FILL_W'(fill_q);
    status[ST_FIFO_CNT_LSB +: ST_FIFO_CNT_W] = ST_FIFO_CNT_W'(fifo_count);
    status[ST_FLUSH_BIT]    = flush_q;
    status[ST_BUSY_BIT]     = (state_q != ST_IDLE) || !fifo_empty || flush_q;
    status[ST_OVERFLOW_BIT] = ovf_q;

    rdata_d = rd_status ? status : 32'd0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      acc_q   <= '0;
      enc_q   <= '0;
      en_q    <= 1'b0;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
      enc_q   <= enc_d;
      en_q    <= en_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign encoded_out  = enc_q;
  assign enable_out   = en_q;
  assign bus.readdata = rdata_q;

endmodule
